// File: rtl/mem_responder.sv
// Word-addressed on-chip memory acting as the responder end of the valid/ready
// memory handshake, with programmable wait states and byte-masked writes.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic                    oor_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              wstrb_reg;
  logic                    ready_reg, err_reg, rd_en_reg;

  logic [31:0]             addr_hi;
  logic                    req_oor;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic                    cur_oor;
  logic [3:0]              cur_wstrb;
  logic                    resp_next;
  logic                    wr_en;
  logic [31:0]             ram_q;
  logic                    unused_addr_bits;

  assign addr_hi          = mem_addr >> (ADDR_WIDTH + 2);
  assign req_oor          = |addr_hi;
  assign unused_addr_bits = ^mem_addr[1:0];

  // In IDLE the request is being accepted this edge, so use the live inputs.
  always_comb begin
    cur_idx   = idx_reg;
    cur_oor   = oor_reg;
    cur_wstrb = wstrb_reg;
    if (state_reg == IDLE) begin
      cur_idx   = mem_addr[ADDR_WIDTH+1:2];
      cur_oor   = req_oor;
      cur_wstrb = mem_wstrb;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mem_valid) begin
          cnt_next   = LAT4;
          state_next = (LAT4 == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_next = (state_next == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      oor_reg   <= 1'b0;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'h0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rd_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && mem_valid) begin
        idx_reg   <= mem_addr[ADDR_WIDTH+1:2];
        oor_reg   <= req_oor;
        wdata_reg <= mem_wdata;
        wstrb_reg <= mem_wstrb;
      end
      ready_reg <= resp_next;
      err_reg   <= resp_next && cur_oor;
      rd_en_reg <= resp_next && !cur_oor && (cur_wstrb == 4'h0);
    end
  end

  // Writes land at the edge ending RESP, so a withdrawn request never commits.
  assign wr_en = (state_reg == RESP) && !oor_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wstrb_reg[gi])
        bank[idx_reg] <= wdata_reg[8*gi +: 8];
      if (resp_next)
        q_reg <= bank[cur_idx];
    end

    assign ram_q[8*gi +: 8] = q_reg;
  end

  assign mem_ready = ready_reg;
  assign mem_err   = err_reg;
  assign mem_rdata = rd_en_reg ? ram_q : 32'h0;

endmodule
